// File: rtl/io_port_responder.sv
// Peripheral responder for the core's INPUT/OUTPUT port strobes: TX/RX byte FIFOs,
// a GPIO output latch, synchronized GPIO inputs, sticky overflow flags and an irq level.
module io_port_responder #(
    parameter int         TX_DEPTH  = 4,
    parameter int         RX_DEPTH  = 4,
    parameter logic [7:0] PORT_BASE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] gpio_out,
    input  logic [7:0] gpio_in,
    output logic       irq
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    localparam logic [7:0] OFF_STATUS   = 8'd0;
    localparam logic [7:0] OFF_TXDATA   = 8'd1;
    localparam logic [7:0] OFF_RXDATA   = 8'd2;
    localparam logic [7:0] OFF_GPIO_OUT = 8'd3;
    localparam logic [7:0] OFF_GPIO_IN  = 8'd4;
    localparam logic [7:0] OFF_CTRL     = 8'd5;

    // Subtraction wraps, so ports below PORT_BASE land on large offsets and decode as unmapped.
    logic [7:0] offset;
    assign offset = port_id - PORT_BASE;

    logic wr_txdata, wr_gpio_out, wr_ctrl, rd_rxdata;
    assign wr_txdata   = IO_write_strobe && (offset == OFF_TXDATA);
    assign wr_gpio_out = IO_write_strobe && (offset == OFF_GPIO_OUT);
    assign wr_ctrl     = IO_write_strobe && (offset == OFF_CTRL);
    assign rd_rxdata   = IO_read_strobe  && (offset == OFF_RXDATA);

    logic flag_clear, tx_flush;
    assign flag_clear = wr_ctrl && IO_write_data[0];
    assign tx_flush   = wr_ctrl && IO_write_data[1];

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic           tx_empty, tx_full;
    logic           tx_push_req, tx_push, tx_pop, tx_ovf_set;

    assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    assign tx_full  = (tx_wr_ptr_reg[TX_AW] != tx_rd_ptr_reg[TX_AW]) &&
                      (tx_wr_ptr_reg[TX_AW-1:0] == tx_rd_ptr_reg[TX_AW-1:0]);

    assign tx_pop      = !tx_empty && tx_ready;
    // A flush in the same cycle swallows the push outright, including any overflow it would cause.
    assign tx_push_req = wr_txdata && !tx_flush;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
        end else begin
            if (tx_push)
                tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_flush)
                tx_rd_ptr_reg <= tx_wr_ptr_reg;
            else if (tx_pop)
                tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg[TX_AW-1:0]] <= IO_write_data;
    end

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr_reg[TX_AW-1:0]];

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic           rx_empty, rx_full;
    logic           rx_accept, rx_pop;
    logic [7:0]     rx_head;

    assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
    assign rx_full  = (rx_wr_ptr_reg[RX_AW] != rx_rd_ptr_reg[RX_AW]) &&
                      (rx_wr_ptr_reg[RX_AW-1:0] == rx_rd_ptr_reg[RX_AW-1:0]);

    assign rx_ready  = !rx_full;
    assign rx_accept = rx_valid && !rx_full;
    assign rx_pop    = rd_rxdata && !rx_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
        end else begin
            if (rx_accept)
                rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)
                rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_accept)
            rx_mem[rx_wr_ptr_reg[RX_AW-1:0]] <= rx_data;
    end

    assign rx_head = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg[RX_AW-1:0]];

    // rx overflow only after the producer has been stalled 256 consecutive cycles.
    logic       rx_stall, rx_ovf_set;
    logic [7:0] stall_cnt_reg;

    assign rx_stall   = rx_valid && rx_full;
    assign rx_ovf_set = rx_stall && (stall_cnt_reg == 8'hFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_reg <= 8'h00;
        else if (!rx_stall)
            stall_cnt_reg <= 8'h00;
        else
            stall_cnt_reg <= stall_cnt_reg + 8'd1;
    end

    // ---------------- Sticky flags (set beats clear) ----------------
    logic tx_ovf_reg, rx_ovf_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf_reg <= 1'b0;
            rx_ovf_reg <= 1'b0;
        end else begin
            if (tx_ovf_set)
                tx_ovf_reg <= 1'b1;
            else if (flag_clear)
                tx_ovf_reg <= 1'b0;
            if (rx_ovf_set)
                rx_ovf_reg <= 1'b1;
            else if (flag_clear)
                rx_ovf_reg <= 1'b0;
        end
    end

    // ---------------- GPIO ----------------
    logic [7:0] gpio_out_reg, gpio_meta_reg, gpio_sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_reg  <= 8'h00;
            gpio_meta_reg <= 8'h00;
            gpio_sync_reg <= 8'h00;
        end else begin
            if (wr_gpio_out)
                gpio_out_reg <= IO_write_data;
            gpio_meta_reg <= gpio_in;
            gpio_sync_reg <= gpio_meta_reg;
        end
    end

    assign gpio_out = gpio_out_reg;

    // ---------------- Read mux (purely combinational on port_id) ----------------
    logic [7:0] status;
    assign status = {3'b000, rx_ovf_reg, tx_ovf_reg, !rx_empty, tx_full, tx_empty};

    always_comb begin
        IO_read_data = 8'h00;
        case (offset)
            OFF_STATUS:   IO_read_data = status;
            OFF_RXDATA:   IO_read_data = rx_head;
            OFF_GPIO_OUT: IO_read_data = gpio_out_reg;
            OFF_GPIO_IN:  IO_read_data = gpio_sync_reg;
            default:      IO_read_data = 8'h00;
        endcase
    end

    assign irq = !rx_empty || tx_ovf_reg || rx_ovf_reg;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: TX/RX byte expectations are queued when
// stimulus is driven and popped when the DUT presents the byte.
module tb_io_port_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] port_id;
    logic [7:0] IO_write_data;
    logic       IO_write_strobe;
    logic       IO_read_strobe;
    logic [7:0] IO_read_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] gpio_out;
    logic [7:0] gpio_in;
    logic       irq;

    io_port_responder #(
        .TX_DEPTH (4),
        .RX_DEPTH (4),
        .PORT_BASE(8'h00)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .port_id        (port_id),
        .IO_write_data  (IO_write_data),
        .IO_write_strobe(IO_write_strobe),
        .IO_read_strobe (IO_read_strobe),
        .IO_read_data   (IO_read_data),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .gpio_out       (gpio_out),
        .gpio_in        (gpio_in),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {7'b0, obs}, {7'b0, exp});
    endtask

    task automatic tx_check(input string tag);
        logic [7:0] exp;
        if (tx_q.size() == 0) exp = 8'hxx;
        else exp = tx_q.pop_front();
        check(tag, tx_data, exp);
    endtask

    task automatic peek(input logic [7:0] p, output logic [7:0] obs);
        port_id = p;
        #1;
        obs = IO_read_data;
    endtask

    task automatic io_write(input logic [7:0] p, input logic [7:0] d);
        @(negedge clk);
        port_id = p;
        IO_write_data = d;
        IO_write_strobe = 1'b1;
        @(negedge clk);
        IO_write_strobe = 1'b0;
    endtask

    // Callers hold tx_ready low, so the model just caps at the FIFO depth.
    task automatic tx_write(input logic [7:0] d);
        io_write(8'h01, d);
        if (tx_q.size() < 4) tx_q.push_back(d);
    endtask

    task automatic io_read(input logic [7:0] p, output logic [7:0] obs);
        @(negedge clk);
        port_id = p;
        IO_read_strobe = 1'b1;
        #1;
        obs = IO_read_data;
        @(negedge clk);
        IO_read_strobe = 1'b0;
    endtask

    task automatic rx_read_check(input string tag);
        logic [7:0] obs, exp;
        io_read(8'h02, obs);
        if (rx_q.size() == 0) exp = 8'hxx;
        else exp = rx_q.pop_front();
        check(tag, obs, exp);
    endtask

    initial begin
        logic [7:0] obs;
        rst_n = 1'b0;
        port_id = 8'h00;
        IO_write_data = 8'h00;
        IO_write_strobe = 1'b0;
        IO_read_strobe = 1'b0;
        tx_ready = 1'b0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        gpio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        peek(8'h00, obs);
        check("status_reset", obs, 8'h01);
        check_bit("rx_ready_reset", rx_ready, 1'b1);
        check_bit("tx_valid_reset", tx_valid, 1'b0);
        check("gpio_out_reset", gpio_out, 8'h00);
        check("tx_data_reset", tx_data, 8'h00);
        check_bit("irq_reset", irq, 1'b0);

        // TX overflow: A5 is dropped
        for (int i = 0; i < 5; i++) tx_write(8'hA1 + 8'(i));
        peek(8'h00, obs);
        check("status_tx_ovf", obs, 8'h0A);
        check_bit("irq_tx_ovf", irq, 1'b1);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_bit("tx_valid_drain", tx_valid, 1'b1);
            tx_check("tx_drain_a");
            @(negedge clk);
        end
        check_bit("tx_valid_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;
        io_write(8'h05, 8'h01);
        peek(8'h00, obs);
        check("status_after_clear", obs, 8'h01);
        check_bit("irq_after_clear", irq, 1'b0);

        // RX path
        @(negedge clk);
        rx_data = 8'h5C; rx_valid = 1'b1; rx_q.push_back(8'h5C);
        @(negedge clk);
        rx_data = 8'h33; rx_q.push_back(8'h33);
        @(negedge clk);
        rx_valid = 1'b0;
        check_bit("irq_rx_nonempty", irq, 1'b1);
        rx_read_check("rx_read_1");
        rx_read_check("rx_read_2");
        io_read(8'h02, obs);
        check("rx_read_empty", obs, 8'h00);
        peek(8'h00, obs);
        check("status_rx_empty", obs, 8'h01);
        check_bit("irq_rx_empty", irq, 1'b0);

        // Push and pop together while full: no overflow
        for (int i = 0; i < 4; i++) tx_write(8'hB0 + 8'(i));
        peek(8'h00, obs);
        check("status_tx_full", obs, 8'h02);
        @(negedge clk);
        port_id = 8'h01; IO_write_data = 8'hB4; IO_write_strobe = 1'b1; tx_ready = 1'b1;
        tx_check("tx_simul_head");
        tx_q.push_back(8'hB4);
        @(negedge clk);
        IO_write_strobe = 1'b0; tx_ready = 1'b0;
        peek(8'h00, obs);
        check("status_simul_no_ovf", obs, 8'h02);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_check("tx_drain_b");
            @(negedge clk);
        end
        check_bit("tx_valid_empty_b", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // GPIO
        io_write(8'h03, 8'hC3);
        check("gpio_out_latch", gpio_out, 8'hC3);
        peek(8'h03, obs);
        check("gpio_out_read", obs, 8'hC3);
        peek(8'h06, obs);
        check("unmapped_read", obs, 8'h00);
        @(negedge clk);
        gpio_in = 8'h7E;
        @(negedge clk);
        peek(8'h04, obs);
        check("gpio_in_1cyc", obs, 8'h00);
        @(negedge clk);
        peek(8'h04, obs);
        check("gpio_in_2cyc", obs, 8'h7E);

        // Both overflow flags
        for (int i = 0; i < 5; i++) tx_write(8'hD0 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_data = 8'hE0 + 8'(i); rx_valid = 1'b1; rx_q.push_back(rx_data);
        end
        @(negedge clk);
        rx_data = 8'hEE;
        check_bit("rx_ready_full", rx_ready, 1'b0);
        repeat (255) @(negedge clk);
        peek(8'h00, obs);
        check("status_stall_255", obs, 8'h0E);
        @(negedge clk);
        peek(8'h00, obs);
        check("status_stall_256", obs, 8'h1E);
        rx_valid = 1'b0;
        io_write(8'h05, 8'h03);
        tx_q.delete();
        peek(8'h00, obs);
        check("status_clear_flush", obs, 8'h05);
        check_bit("tx_valid_flushed", tx_valid, 1'b0);
        check_bit("irq_rx_pending", irq, 1'b1);
        rx_read_check("rx_read_after_flush");

        // Reset mid-drain
        tx_write(8'hF0);
        tx_write(8'hF1);
        @(negedge clk);
        tx_ready = 1'b1;
        tx_check("tx_drain_f0");
        @(negedge clk);
        tx_check("tx_drain_f1");
        #2 rst_n = 1'b0;
        #1;
        check_bit("tx_valid_mid_reset", tx_valid, 1'b0);
        check("tx_data_mid_reset", tx_data, 8'h00);
        check_bit("rx_ready_mid_reset", rx_ready, 1'b1);
        check("gpio_out_mid_reset", gpio_out, 8'h00);
        check_bit("irq_mid_reset", irq, 1'b0);
        peek(8'h00, obs);
        check("status_mid_reset", obs, 8'h01);
        tx_q.delete();
        rx_q.delete();
        tx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        peek(8'h00, obs);
        check("status_after_reset", obs, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
